// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, one transaction at a
// time. Define MEM_ARB_FAIR_EN to bound how long fetches can be starved by data accesses.
module mem_port_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_ack,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_dm_req,
    input  logic          i_dm_we,
    input  logic [AW-1:0] i_dm_addr,
    input  logic [DW-1:0] i_dm_wdata,
    output logic          o_dm_ack,
    output logic [DW-1:0] o_dm_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy
);

    localparam int unsigned CntW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_nxt;
    logic            w_if_wins;
    logic            w_grant_if;
    logic            w_grant_dm;
    logic            w_cnt_last;
    logic            w_busy;

    logic            r_win_dm;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [CntW-1:0] r_cnt;
    logic [DW-1:0]   r_if_rdata;
    logic [DW-1:0]   r_dm_rdata;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [2:0] StarveLim = 3'(STARVE_MAX);

    // Consecutive arbitrations the fetch side has lost while it was requesting.
    logic [2:0] r_loss;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_loss <= 3'd0;
        end else if (w_grant_if) begin
            r_loss <= 3'd0;
        end else if (w_grant_dm && i_if_req && (r_loss != 3'd7)) begin
            r_loss <= r_loss + 3'd1;
        end
    end

    assign w_if_wins = i_if_req && (!i_dm_req || (r_loss >= StarveLim));
`else
    logic w_unused_starve;
    assign w_unused_starve = (STARVE_MAX != 0);

    // Data side always wins: it belongs to the older instruction in the pipe.
    assign w_if_wins = i_if_req && !i_dm_req;
`endif

    assign w_cnt_last = (r_cnt == CntW'(1));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_dm  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_if_wins) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = StIssue;
                end else if (i_dm_req) begin
                    w_grant_dm  = 1'b1;
                    w_state_nxt = StIssue;
                end
            end
            StIssue: w_state_nxt = StWait;
            StWait: begin
                if (w_cnt_last) begin
                    w_state_nxt = StDone;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_win_dm   <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            if (w_grant_if) begin
                r_win_dm <= 1'b0;
                r_we     <= 1'b0;
                r_addr   <= i_if_addr;
                r_wdata  <= '0;
            end else if (w_grant_dm) begin
                r_win_dm <= 1'b1;
                r_we     <= i_dm_we;
                r_addr   <= i_dm_addr;
                r_wdata  <= i_dm_wdata;
            end

            if (r_state == StIssue) begin
                r_cnt <= CntW'(MEM_LAT);
            end else if (r_state == StWait) begin
                r_cnt <= r_cnt - CntW'(1);
                // Memory data is valid in the last wait cycle; stores report zero.
                if (w_cnt_last) begin
                    if (r_win_dm) begin
                        r_dm_rdata <= r_we ? '0 : i_mem_rdata;
                    end else begin
                        r_if_rdata <= i_mem_rdata;
                    end
                end
            end
        end
    end

    assign w_busy      = (r_state != StIdle);
    assign o_busy      = w_busy;
    assign o_mem_en    = (r_state == StIssue);
    assign o_mem_we    = (r_state == StIssue) && r_we;
    assign o_mem_addr  = w_busy ? r_addr : '0;
    assign o_mem_wdata = w_busy ? r_wdata : '0;
    assign o_if_ack    = (r_state == StDone) && !r_win_dm;
    assign o_dm_ack    = (r_state == StDone) && r_win_dm;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing cases plus randomized traffic from
// independent fetch and data requesters against a word-array memory reference.
module tb_mem_port_arbiter;

    localparam int unsigned MEM_LAT    = 3;
    localparam int unsigned STARVE_MAX = 4;
    localparam int          NRAND      = 40;
`ifdef MEM_ARB_FAIR_EN
    localparam int          DM_BEFORE_IF = 4;
`else
    localparam int          DM_BEFORE_IF = 5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'h0;
    logic [31:0] dm_wdata = 32'h0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_en  = 0;
    int n_ack = 0;

    logic [31:0] exp_if[$];
    logic [31:0] exp_dm[$];
    logic [31:0] ref_mem[256];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(32), .DW(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack), .o_if_rdata(if_rdata),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
        .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) << 12) ^ 32'h0000_0013;
    endfunction

    // Memory device: synchronous write, read data valid MEM_LAT cycles after the strobe.
    logic [31:0] dev[256];
    logic [31:0] pipe[MEM_LAT];
    logic        dev_ready = 1'b0;

    always @(posedge clk) begin
        if (!dev_ready) begin
            for (int i = 0; i < 256; i++) dev[i] <= init_word(i);
            dev_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            dev[mem_addr[9:2]] <= mem_wdata;
        end
        for (int i = MEM_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= mem_en ? dev[mem_addr[9:2]] : 32'hBAD0_BAD0;
    end

    assign mem_rdata = pipe[MEM_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever an ack is presented.
    always @(negedge clk) begin
        if (rst) begin
            if (mem_en) n_en++;
            if (if_ack && dm_ack) begin
                n_cmp++;
                n_err++;
                $display("FAIL dual_ack: if_ack and dm_ack high in the same cycle");
            end
            if (if_ack) begin
                n_ack++;
                check("if_ack_busy", 32'(busy), 32'h1);
                if (exp_if.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL if_unexpected_ack: ack with empty scoreboard");
                end else begin
                    check("if_rdata", if_rdata, exp_if.pop_front());
                end
            end
            if (dm_ack) begin
                n_ack++;
                check("dm_ack_busy", 32'(busy), 32'h1);
                if (exp_dm.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL dm_unexpected_ack: ack with empty scoreboard");
                end else begin
                    check("dm_rdata", dm_rdata, exp_dm.pop_front());
                end
            end
        end
    end

    // Runs from cycle 0 (requests already driven); each requester drops on the edge after ack.
    task automatic run_txn(input int max_cyc, output int if_c, output int dm_c, output int en_c,
                           output logic en_we, output logic [31:0] en_addr,
                           output logic [31:0] en_wdata, output logic [31:0] done_addr);
        if_c = -1; dm_c = -1; en_c = -1;
        en_we = 1'b0; en_addr = 32'h0; en_wdata = 32'h0; done_addr = 32'h0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (if_c == c - 1) if_req = 1'b0;
            if (dm_c == c - 1) dm_req = 1'b0;
            if (mem_en && en_c < 0) begin
                en_c = c; en_we = mem_we; en_addr = mem_addr; en_wdata = mem_wdata;
            end
            if (if_ack && if_c < 0) begin if_c = c; done_addr = mem_addr; end
            if (dm_ack && dm_c < 0) begin dm_c = c; done_addr = mem_addr; end
            if (!if_req && !dm_req) break;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    task automatic wait_ack(input logic is_dm, output logic got);
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (is_dm ? dm_ack : if_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ic, dc, ec, acks, nd, ni, dm_first;
        logic        ewe, drop_dm, drop_if;
        logic [31:0] ea, ewd, da;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_acks", 32'({if_ack, dm_ack}), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_dm_rdata", dm_rdata, 32'h0);
        @(negedge clk) rst = 1'b1;

        // Single fetch
        @(posedge clk); #1;
        if_addr = 32'h10; exp_if.push_back(ref_mem[4]); if_req = 1'b1;
        run_txn(40, ic, dc, ec, ewe, ea, ewd, da);
        check("fetch_mem_en_cycle", ec, 1);
        check("fetch_ack_cycle", ic, MEM_LAT + 2);
        check("fetch_addr_held", da, 32'h10);
        check("fetch_idle_after", 32'(busy), 32'h0);

        // Simultaneous fetch and load: data side first
        @(posedge clk); #1;
        if_addr = 32'h20; exp_if.push_back(ref_mem[8]);
        dm_addr = 32'h40; dm_we = 1'b0; exp_dm.push_back(ref_mem[16]);
        if_req = 1'b1; dm_req = 1'b1;
        run_txn(60, ic, dc, ec, ewe, ea, ewd, da);
        check("both_dm_ack_cycle", dc, MEM_LAT + 2);
        check("both_if_ack_cycle", ic, 2 * MEM_LAT + 5);
        check("both_first_addr", ea, 32'h40);

        // Store
        @(posedge clk); #1;
        dm_addr = 32'h80; dm_we = 1'b1; dm_wdata = 32'hDEAD_BEEF;
        ref_mem[32] = 32'hDEAD_BEEF; exp_dm.push_back(32'h0); dm_req = 1'b1;
        run_txn(40, ic, dc, ec, ewe, ea, ewd, da);
        check("store_mem_en_cycle", ec, 1);
        check("store_mem_we", 32'(ewe), 32'h1);
        check("store_mem_addr", ea, 32'h80);
        check("store_mem_wdata", ewd, 32'hDEAD_BEEF);
        check("store_ack_cycle", dc, MEM_LAT + 2);
        check("store_addr_held", da, 32'h80);
        dm_we = 1'b0;

        // Load back the stored word
        @(posedge clk); #1;
        dm_addr = 32'h80; exp_dm.push_back(32'hDEAD_BEEF); dm_req = 1'b1;
        run_txn(40, ic, dc, ec, ewe, ea, ewd, da);
        check("load_ack_cycle", dc, MEM_LAT + 2);

        // Reset in the middle of a wait
        @(posedge clk); #1;
        if_addr = 32'h14; if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_mem_en", 32'(mem_en), 32'h0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_if_rdata", if_rdata, 32'h0);
        check("midrst_dm_rdata", dm_rdata, 32'h0);
        if_req = 1'b0;
        @(negedge clk) rst = 1'b1;
        acks = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (if_ack || dm_ack) acks++;
        end
        check("no_ack_after_reset", acks, 0);

        // Both requests held: count data grants before the first fetch grant
        repeat (5) exp_dm.push_back(ref_mem[128]);
        exp_if.push_back(ref_mem[9]);
        @(posedge clk); #1;
        dm_we = 1'b0; dm_addr = 32'h200; if_addr = 32'h24; dm_req = 1'b1; if_req = 1'b1;
        nd = 0; ni = 0; dm_first = -1; drop_dm = 1'b0; drop_if = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (drop_dm) begin dm_req = 1'b0; drop_dm = 1'b0; end
            if (drop_if) begin if_req = 1'b0; drop_if = 1'b0; end
            if (dm_ack) begin
                nd++;
                if (nd == 5) drop_dm = 1'b1;
            end
            if (if_ack) begin
                ni++;
                if (dm_first < 0) dm_first = nd;
                drop_if = 1'b1;
            end
            if (!dm_req && !if_req) break;
        end
        dm_req = 1'b0; if_req = 1'b0;
        check("starve_dm_before_if", dm_first, DM_BEFORE_IF);
        check("starve_dm_total", nd, 5);
        check("starve_if_total", ni, 1);

        // Random traffic: fetches in words 0..63, data in words 64..127
        fork
            begin
                for (int n = 0; n < NRAND; n++) begin
                    int   w;
                    logic got;
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    w = $urandom_range(0, 63);
                    if_addr = 32'(w) << 2;
                    exp_if.push_back(ref_mem[w]);
                    if_req = 1'b1;
                    wait_ack(1'b0, got);
                    check("if_ack_in_bound", 32'(got), 32'h1);
                    @(posedge clk); #1;
                    if_req = 1'b0;
                end
            end
            begin
                for (int n = 0; n < NRAND; n++) begin
                    int   w;
                    logic got;
                    repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    w = $urandom_range(64, 127);
                    dm_addr  = 32'(w) << 2;
                    dm_we    = ($urandom_range(0, 1) == 1);
                    dm_wdata = $urandom;
                    if (dm_we) begin
                        ref_mem[w] = dm_wdata;
                        exp_dm.push_back(32'h0);
                    end else begin
                        exp_dm.push_back(ref_mem[w]);
                    end
                    dm_req = 1'b1;
                    wait_ack(1'b1, got);
                    check("dm_ack_in_bound", 32'(got), 32'h1);
                    @(posedge clk); #1;
                    dm_req = 1'b0;
                end
            end
        join

        repeat (4) @(posedge clk);
        #1;
        check("if_scoreboard_drained", exp_if.size(), 0);
        check("dm_scoreboard_drained", exp_dm.size(), 0);
        // One strobe belongs to the access aborted by reset
        check("strobes_vs_acks", n_en, n_ack + 1);
        check("final_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
